decrypt_serial: RTL



---
 rtl/decrypt_serial_if.sv | 29 ++
 rtl/decrypt_serial.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/decrypt_serial_if.sv
// decrypt_serial_if
//   Groups the byte-serial ciphertext handshake, the round-key fetch bus and
//   the plaintext result of decrypt_serial.
//   enable/in/in_ready : ciphertext byte strobe, byte and ready
//   key/key_round/key_idx : key-store read data and the address driving it
//   message/done/busy : plaintext, one-cycle completion pulse, activity flag
//   master : the side that feeds bytes and serves key bytes
//   slave  : the decrypt block itself
interface decrypt_serial_if;
  logic         enable;
  logic [7:0]   in;
  logic         in_ready;
  logic [7:0]   key;
  logic [3:0]   key_round;
  logic [3:0]   key_idx;
  logic [127:0] message;
  logic         done;
  logic         busy;

  modport master (
    output enable, in, key,
    input  in_ready, key_round, key_idx, message, done, busy
  );

  modport slave (
    input  enable, in, key,
    output in_ready, key_round, key_idx, message, done, busy
  );
endinterface

// File: rtl/decrypt_serial.sv
// decrypt_serial
//   Byte-serial AES-128 inverse cipher. Sixteen ciphertext bytes are shifted
//   in (first byte = FIPS byte 0), then the inverse cipher runs one byte or
//   one column per cycle, reading round-key bytes from an external store.
//   Ports:
//     clock    : rising-edge clock
//     reset_n  : asynchronous active-low reset
//     bus      : decrypt_serial_if.slave (strobe/byte in, key fetch, result)
//   Build option:
//     DECRYPT_FUSED_SB_EN : merge InvSubBytes into the following AddRoundKey
//                           pass (222-cycle latency instead of 382).
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for the first ciphertext byte
//   LOAD  | shifting in ciphertext bytes 1..15
//   ARK   | AddRoundKey, one byte per cycle (fused with InvSubBytes
//         | for rounds 9..0 when DECRYPT_FUSED_SB_EN is defined)
//   ISR   | InvShiftRows, single-cycle permutation
//   ISB   | InvSubBytes, one byte per cycle (separate-pass build only)
//   IMC   | InvMixColumns, one column per cycle
//   DONE  | plaintext published, done pulse
module decrypt_serial (
  input  logic           clock,
  input  logic           reset_n,
  decrypt_serial_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARK,
    ISR,
`ifndef DECRYPT_FUSED_SB_EN
    ISB,
`endif
    IMC,
    DONE
  } state_t;

  state_t       state;
  logic [127:0] st;
  logic [3:0]   cnt;
  logic [3:0]   rnd;
  logic [127:0] message_q;
  logic         done_q;
  logic         busy_q;
  logic         in_ready_q;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = gf_xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0, as the S-box needs).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
    return gf_mul(r, r);
  endfunction

  // Inverse affine transform followed by field inversion.
  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  logic [7:0]   sb [16];
  logic [7:0]   nb [16];
  logic [127:0] st_nxt;
  logic [3:0]   col;
  logic [7:0]   a0, a1, a2, a3;

  always_comb begin
    for (int i = 0; i < 16; i++) sb[i] = st[127-8*i -: 8];
    for (int i = 0; i < 16; i++) nb[i] = sb[i];
    col = {cnt[1:0], 2'b00};
    a0  = sb[col];
    a1  = sb[col + 4'd1];
    a2  = sb[col + 4'd2];
    a3  = sb[col + 4'd3];
    case (state)
      ARK: begin
`ifdef DECRYPT_FUSED_SB_EN
        if (rnd == 4'd10) nb[cnt] = sb[cnt] ^ bus.key;
        else              nb[cnt] = inv_sbox(sb[cnt]) ^ bus.key;
`else
        nb[cnt] = sb[cnt] ^ bus.key;
`endif
      end
      ISR: begin
        // byte (row r, column c) moves to column (c + r) mod 4
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            nb[r + 4*((c + r) % 4)] = sb[r + 4*c];
      end
`ifndef DECRYPT_FUSED_SB_EN
      ISB: nb[cnt] = inv_sbox(sb[cnt]);
`endif
      IMC: begin
        nb[col]        = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
        nb[col + 4'd1] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
        nb[col + 4'd2] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
        nb[col + 4'd3] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      default: ;
    endcase
    st_nxt = '0;
    for (int i = 0; i < 16; i++) st_nxt[127-8*i -: 8] = nb[i];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      st         <= '0;
      cnt        <= 4'd0;
      rnd        <= 4'd0;
      message_q  <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            st     <= {st[119:0], bus.in};
            cnt    <= 4'd1;
            busy_q <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (bus.enable) begin
            st  <= {st[119:0], bus.in};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              rnd        <= 4'd10;
              in_ready_q <= 1'b0;
              state      <= ARK;
            end
          end
        end
        ARK: begin
          st  <= st_nxt;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            if (rnd == 4'd10) begin
              rnd   <= 4'd9;
              state <= ISR;
            end else if (rnd == 4'd0) begin
              // publish on the same edge that completes the last byte
              message_q <= st_nxt;
              done_q    <= 1'b1;
              state     <= DONE;
            end else begin
              state <= IMC;
            end
          end
        end
        ISR: begin
          st <= st_nxt;
`ifdef DECRYPT_FUSED_SB_EN
          state <= ARK;
`else
          state <= ISB;
`endif
        end
`ifndef DECRYPT_FUSED_SB_EN
        ISB: begin
          st  <= st_nxt;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) state <= ARK;
        end
`endif
        IMC: begin
          st <= st_nxt;
          if (cnt == 4'd3) begin
            cnt   <= 4'd0;
            rnd   <= rnd - 4'd1;
            state <= ISR;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          busy_q     <= 1'b0;
          in_ready_q <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.key_round = rnd;
  assign bus.key_idx   = cnt;
  assign bus.message   = message_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;

endmodule
